// File: rtl/text_grid_render_ctl_pkg.sv
// Shared geometry constants and the VGA timing bundle used by the
// 16x16 text grid overlay and its delay line.
package text_grid_pkg;

    localparam int TEXT_COLS = 16;
    localparam int TEXT_ROWS = 16;
    localparam int CHAR_W    = 8;
    localparam int CHAR_H    = 16;
    localparam int BOX_W     = TEXT_COLS * CHAR_W;
    localparam int BOX_H     = TEXT_ROWS * CHAR_H;
    localparam int PIPE_LAT  = 3;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vga_timing_t;

endpackage

// File: rtl/text_grid_render_ctl_if.sv
// VGA stream in/out plus the char-code/font ROM address and data lines
// of the text grid overlay; the parent (master) owns both ROMs.
interface text_grid_render_ctl_if;

    logic        text_en;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;

    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [7:0]  char_pixels;

    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    modport master (
        output text_en, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        output char_pixels,
        input  char_xy, char_line,
        input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
    );

    modport slave (
        input  text_en, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
        input  char_pixels,
        output char_xy, char_line,
        output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
    );

endinterface

// File: rtl/text_grid_render_ctl_vga_timing_delay.sv
// N-stage register delay for the VGA timing bundle and its pixel colour,
// keeping them aligned with the ROM lookup pipeline.
module vga_timing_delay
    import text_grid_pkg::*;
#(
    parameter int N = 2
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  vga_timing_t timing_in,
    input  logic [11:0] rgb_in,
    output vga_timing_t timing_out,
    output logic [11:0] rgb_out
);

    vga_timing_t timing_q [N];
    logic [11:0] rgb_q    [N];

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                timing_q[i] <= '0;
                rgb_q[i]    <= '0;
            end
        end else begin
            timing_q[0] <= timing_in;
            rgb_q[0]    <= rgb_in;
            for (int i = 1; i < N; i++) begin
                timing_q[i] <= timing_q[i-1];
                rgb_q[i]    <= rgb_q[i-1];
            end
        end
    end

    assign timing_out = timing_q[N-1];
    assign rgb_out    = rgb_q[N-1];

endmodule

// File: rtl/text_grid_render_ctl.sv
// Overlays a 16x16 grid of 8x16 glyphs on the VGA stream: addresses the
// char-code and font ROMs, realigns the font row and applies enable/blink.
module text_grid_render_ctl
    import text_grid_pkg::*;
#(
    parameter logic [10:0] X_POS        = 11'd0,
    parameter logic [10:0] Y_POS        = 11'd0,
    parameter logic [11:0] TEXT_COLOR   = 12'hFFF,
    parameter logic [7:0]  BLINK_FRAMES = 8'd0
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    text_grid_render_ctl_if.slave bus
);

    localparam logic [11:0] X_LO = {1'b0, X_POS};
    localparam logic [11:0] X_HI = X_LO + 12'(BOX_W);
    localparam logic [11:0] Y_LO = {1'b0, Y_POS};
    localparam logic [11:0] Y_HI = Y_LO + 12'(BOX_H);

    logic        in_box;
    logic [6:0]  rel_x;
    logic [7:0]  rel_y;
    logic        in_box0;
    logic        in_box1;
    logic [2:0]  bit_idx0;
    logic [2:0]  bit_idx1;
    logic        pix;
    logic        draw;
    logic        vsync_q;
    logic        vsync_rise;
    logic        en_frame;
    logic        visible;
    logic [7:0]  cnt;
    vga_timing_t timing_in;
    vga_timing_t timing_d2;
    logic [11:0] rgb_d2;

    // Box test on 12-bit extended counts so X_POS+128 cannot wrap.
    always_comb begin
        in_box = ({1'b0, bus.hcount_in} >= X_LO) && ({1'b0, bus.hcount_in} < X_HI) &&
                 ({1'b0, bus.vcount_in} >= Y_LO) && ({1'b0, bus.vcount_in} < Y_HI);
        rel_x  = 7'(bus.hcount_in - X_POS);
        rel_y  = 8'(bus.vcount_in - Y_POS);
    end

    assign timing_in = '{hcount: bus.hcount_in, vcount: bus.vcount_in,
                         hsync:  bus.hsync_in,  vsync:  bus.vsync_in,
                         hblnk:  bus.hblnk_in,  vblnk:  bus.vblnk_in};

    vga_timing_delay #(.N(2)) u_timing_delay (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .timing_in  (timing_in),
        .rgb_in     (bus.rgb_in),
        .timing_out (timing_d2),
        .rgb_out    (rgb_d2)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            bus.char_xy   <= '0;
            bus.char_line <= '0;
            bit_idx0      <= '0;
            in_box0       <= 1'b0;
            bit_idx1      <= '0;
            in_box1       <= 1'b0;
        end else begin
            bus.char_xy   <= in_box ? {rel_y[7:4], rel_x[6:3]} : 8'd0;
            bus.char_line <= in_box ? rel_y[3:0] : 4'd0;
            bit_idx0      <= rel_x[2:0];
            in_box0       <= in_box;
            bit_idx1      <= bit_idx0;
            in_box1       <= in_box0;
        end
    end

    // Frame-level state only changes on a vsync rising edge.
    assign vsync_rise = bus.vsync_in && !vsync_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            en_frame <= 1'b0;
            cnt      <= '0;
            visible  <= 1'b1;
        end else begin
            vsync_q <= bus.vsync_in;
            if (vsync_rise) begin
                en_frame <= bus.text_en;
                if (BLINK_FRAMES != 8'd0) begin
                    if (cnt == BLINK_FRAMES - 8'd1) begin
                        cnt     <= '0;
                        visible <= !visible;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign pix  = bus.char_pixels[3'd7 - bit_idx1];
    assign draw = in_box1 && pix && en_frame && visible && !timing_d2.hblnk && !timing_d2.vblnk;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            bus.hcount_out <= '0;
            bus.vcount_out <= '0;
            bus.hsync_out  <= 1'b0;
            bus.vsync_out  <= 1'b0;
            bus.hblnk_out  <= 1'b0;
            bus.vblnk_out  <= 1'b0;
            bus.rgb_out    <= '0;
        end else begin
            bus.hcount_out <= timing_d2.hcount;
            bus.vcount_out <= timing_d2.vcount;
            bus.hsync_out  <= timing_d2.hsync;
            bus.vsync_out  <= timing_d2.vsync;
            bus.hblnk_out  <= timing_d2.hblnk;
            bus.vblnk_out  <= timing_d2.vblnk;
            bus.rgb_out    <= draw ? TEXT_COLOR : rgb_d2;
        end
    end

endmodule

// File: tb/tb_text_grid_render_ctl.sv
// Self-checking bench for text_grid_render_ctl with a per-cycle scoreboard
// and scenario tasks for reset, glyph drawing, box edges, blanking, blink and enable.
module tb_text_grid_render_ctl;
    import text_grid_pkg::*;

    localparam logic [10:0] XP = 11'd256;
    localparam logic [10:0] YP = 11'd64;
    localparam logic [11:0] TC = 12'hFFF;
    localparam logic [7:0]  BF = 8'd2;

    typedef struct packed {
        logic        in_box;
        logic        pix;
        logic [11:0] rgb;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
    } exp_t;

    logic       pclk      = 1'b0;
    logic       rst_n     = 1'b0;
    logic [7:0] font_byte = 8'h00;
    int         checks    = 0;
    int         errors    = 0;

    exp_t        sb_q [$];
    exp_t        sb_new;
    exp_t        sb_cur;
    logic        sb_valid = 1'b0;
    logic [11:0] exp_rgb;
    logic [7:0]  exp_xy;
    logic [3:0]  exp_line;
    logic        m_vq;
    logic        m_en;
    logic        m_vis;
    int          m_cnt;
    logic [11:0] m_h;
    logic [11:0] m_v;
    logic [10:0] m_rx;
    logic [10:0] m_ry;

    text_grid_render_ctl_if bus ();

    text_grid_render_ctl #(
        .X_POS        (XP),
        .Y_POS        (YP),
        .TEXT_COLOR   (TC),
        .BLINK_FRAMES (BF)
    ) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    // Synchronous font ROM stub: returns font_byte for any address.
    always @(posedge pclk) bus.char_pixels <= font_byte;

    // Reference model: expected outputs queued per input pixel, popped three edges later.
    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q.delete();
            sb_q.push_back('0);
            sb_q.push_back('0);
            sb_valid = 1'b0;
            exp_xy   = '0;
            exp_line = '0;
            m_vq     = 1'b0;
            m_en     = 1'b0;
            m_vis    = 1'b1;
            m_cnt    = 0;
        end else begin
            m_h  = {1'b0, bus.hcount_in};
            m_v  = {1'b0, bus.vcount_in};
            m_rx = bus.hcount_in - XP;
            m_ry = bus.vcount_in - YP;
            sb_new.in_box = (m_h >= {1'b0, XP}) && (m_h < {1'b0, XP} + 12'd128) &&
                            (m_v >= {1'b0, YP}) && (m_v < {1'b0, YP} + 12'd256);
            sb_new.pix = font_byte[7 - int'(m_rx % 11'd8)];
            sb_new.rgb = bus.rgb_in;
            sb_new.h   = bus.hcount_in;
            sb_new.v   = bus.vcount_in;
            sb_new.hs  = bus.hsync_in;
            sb_new.vs  = bus.vsync_in;
            sb_new.hb  = bus.hblnk_in;
            sb_new.vb  = bus.vblnk_in;
            sb_q.push_back(sb_new);
            sb_cur   = sb_q.pop_front();
            exp_rgb  = (sb_cur.in_box && sb_cur.pix && m_en && m_vis && !sb_cur.hb && !sb_cur.vb) ? TC : sb_cur.rgb;
            sb_valid = 1'b1;
            exp_xy   = sb_new.in_box ? 8'((m_ry / 11'd16) * 11'd16 + (m_rx / 11'd8)) : 8'h00;
            exp_line = sb_new.in_box ? 4'(m_ry % 11'd16) : 4'h0;
            if (bus.vsync_in && !m_vq) begin
                m_en = bus.text_en;
                if (m_cnt == int'(BF) - 1) begin
                    m_cnt = 0;
                    m_vis = !m_vis;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_vq = bus.vsync_in;
        end
    end

    always @(negedge pclk) begin
        if (rst_n && sb_valid) begin
            checks++;
            if (bus.rgb_out !== exp_rgb) begin
                errors++;
                $display("[TB] FAIL sb_rgb t=%0t: rgb_out=%h expected %h", $time, bus.rgb_out, exp_rgb);
            end
            checks++;
            if ({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out} !==
                {sb_cur.h, sb_cur.v, sb_cur.hs, sb_cur.vs, sb_cur.hb, sb_cur.vb}) begin
                errors++;
                $display("[TB] FAIL sb_timing t=%0t: h=%0d v=%0d sync/blank=%b expected h=%0d v=%0d sync/blank=%b",
                         $time, bus.hcount_out, bus.vcount_out,
                         {bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out},
                         sb_cur.h, sb_cur.v, {sb_cur.hs, sb_cur.vs, sb_cur.hb, sb_cur.vb});
            end
            checks++;
            if ({bus.char_xy, bus.char_line} !== {exp_xy, exp_line}) begin
                errors++;
                $display("[TB] FAIL sb_addr t=%0t: char_xy=%h char_line=%h expected %h %h",
                         $time, bus.char_xy, bus.char_line, exp_xy, exp_line);
            end
        end
    end

    task automatic set_inputs(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                              input logic hb, input logic vb);
        bus.hcount_in = h;
        bus.vcount_in = v;
        bus.rgb_in    = rgb;
        bus.hblnk_in  = hb;
        bus.vblnk_in  = vb;
        bus.hsync_in  = h[3];
        bus.vsync_in  = 1'b0;
    endtask

    task automatic drive_pixel(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                               input logic hb, input logic vb);
        @(negedge pclk);
        set_inputs(h, v, rgb, hb, vb);
    endtask

    task automatic drive_idle();
        drive_pixel(11'd10, 11'd5, 12'h000, 1'b1, 1'b1);
    endtask

    task automatic frame_start(input logic en_at_rise);
        repeat (3) drive_idle();
        @(negedge pclk);
        set_inputs(11'd10, 11'd5, 12'h000, 1'b1, 1'b1);
        bus.vsync_in = 1'b1;
        bus.text_en  = en_at_rise;
        drive_idle();
    endtask

    task automatic test_reset();
        bus.text_en = 1'b1;
        font_byte   = 8'hFF;
        repeat (3) drive_idle();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.rgb_out, bus.hcount_out, bus.char_xy, bus.char_line} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: rgb_out=%h hcount_out=%0d char_xy=%h char_line=%h expected all 0",
                     bus.rgb_out, bus.hcount_out, bus.char_xy, bus.char_line);
        end
        drive_pixel(11'd300, 11'd100, 12'h456, 1'b0, 1'b0);
        drive_idle();
        drive_idle();
        @(negedge pclk);
        checks++;
        if (bus.rgb_out !== 12'h456) begin
            errors++;
            $display("[TB] FAIL no_text_before_vsync: rgb_out=%h expected 456", bus.rgb_out);
        end
        for (int i = 0; i < 4; i++) drive_pixel(11'd260 + 11'(i), 11'd70, 12'h700 + 12'(i), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rgb_out, bus.hcount_out, bus.vcount_out, bus.char_xy, bus.char_line} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_frame: rgb_out=%h hcount_out=%0d vcount_out=%0d char_xy=%h char_line=%h expected all 0",
                     bus.rgb_out, bus.hcount_out, bus.vcount_out, bus.char_xy, bus.char_line);
        end
        drive_pixel(11'd261, 11'd70, 12'h7F0, 1'b0, 1'b0);
        drive_pixel(11'd262, 11'd70, 12'h7A0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive_pixel(11'd263, 11'd70, 12'h7A1, 1'b0, 1'b0);
        checks++;
        if ({bus.rgb_out, bus.hcount_out} !== '0) begin
            errors++;
            $display("[TB] FAIL post_reset_stage1: rgb_out=%h hcount_out=%0d expected 0", bus.rgb_out, bus.hcount_out);
        end
        drive_idle();
        checks++;
        if ({bus.rgb_out, bus.hcount_out} !== '0) begin
            errors++;
            $display("[TB] FAIL post_reset_stage2: rgb_out=%h hcount_out=%0d expected 0", bus.rgb_out, bus.hcount_out);
        end
        drive_idle();
        checks++;
        if (bus.rgb_out !== 12'h7A0 || bus.hcount_out !== 11'd262) begin
            errors++;
            $display("[TB] FAIL post_reset_first: rgb_out=%h hcount_out=%0d expected 7a0 262", bus.rgb_out, bus.hcount_out);
        end
    endtask

    task automatic test_glyph();
        logic [10:0] h0  [2];
        logic [10:0] v0  [2];
        logic [7:0]  pat [2];
        logic [7:0]  xy  [2];
        logic [3:0]  ln  [2];
        logic [7:0]  p;
        logic [11:0] want;
        h0[0] = 11'd304; v0[0] = 11'd96;  pat[0] = 8'h81; xy[0] = 8'h26; ln[0] = 4'h0;
        h0[1] = 11'd376; v0[1] = 11'd319; pat[1] = 8'hA5; xy[1] = 8'hFF; ln[1] = 4'hF;
        frame_start(1'b1);
        for (int c = 0; c < 2; c++) begin
            repeat (3) drive_idle();
            font_byte = pat[c];
            p         = pat[c];
            for (int t = 0; t < 11; t++) begin
                @(negedge pclk);
                if (t >= 1 && t <= 8) begin
                    checks++;
                    if (bus.char_xy !== xy[c] || bus.char_line !== ln[c]) begin
                        errors++;
                        $display("[TB] FAIL glyph_addr case %0d px %0d: char_xy=%h char_line=%h expected %h %h",
                                 c, t - 1, bus.char_xy, bus.char_line, xy[c], ln[c]);
                    end
                end
                if (t >= 3) begin
                    want = p[10 - t] ? TC : 12'h200 + 12'(t - 3);
                    checks++;
                    if (bus.rgb_out !== want) begin
                        errors++;
                        $display("[TB] FAIL glyph_rgb case %0d px %0d: rgb_out=%h expected %h", c, t - 3, bus.rgb_out, want);
                    end
                end
                if (t < 8) set_inputs(h0[c] + 11'(t), v0[c], 12'h200 + 12'(t), 1'b0, 1'b0);
                else       set_inputs(11'd10, 11'd5, 12'h000, 1'b1, 1'b1);
            end
        end
    endtask

    task automatic test_box_edges();
        logic [10:0] eh [5];
        logic [10:0] ev [5];
        logic [11:0] want;
        eh[0] = 11'd255; ev[0] = 11'd100;
        eh[1] = 11'd384; ev[1] = 11'd100;
        eh[2] = 11'd300; ev[2] = 11'd63;
        eh[3] = 11'd300; ev[3] = 11'd320;
        eh[4] = 11'd256; ev[4] = 11'd64;
        repeat (3) drive_idle();
        font_byte = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            drive_pixel(eh[k], ev[k], 12'h3C0 + 12'(k), 1'b0, 1'b0);
            drive_idle();
            checks++;
            if (bus.char_xy !== 8'h00 || bus.char_line !== 4'h0) begin
                errors++;
                $display("[TB] FAIL edge_addr h=%0d v=%0d: char_xy=%h char_line=%h expected 00 0",
                         eh[k], ev[k], bus.char_xy, bus.char_line);
            end
            drive_idle();
            @(negedge pclk);
            want = (k == 4) ? TC : 12'h3C0 + 12'(k);
            checks++;
            if (bus.rgb_out !== want) begin
                errors++;
                $display("[TB] FAIL edge_rgb h=%0d v=%0d: rgb_out=%h expected %h", eh[k], ev[k], bus.rgb_out, want);
            end
        end
    endtask

    task automatic test_blanking();
        repeat (3) drive_idle();
        font_byte = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            drive_pixel(11'd300, 11'd100, 12'h123, (k == 0), (k == 1));
            drive_idle();
            drive_idle();
            @(negedge pclk);
            checks++;
            if (bus.rgb_out !== 12'h123) begin
                errors++;
                $display("[TB] FAIL blank_rgb %0d: rgb_out=%h expected 123", k, bus.rgb_out);
            end
            checks++;
            if (bus.hcount_out !== 11'd300 || bus.vcount_out !== 11'd100 ||
                {bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out} !== {1'b1, 1'b0, (k == 0), (k == 1)}) begin
                errors++;
                $display("[TB] FAIL blank_timing %0d: h=%0d v=%0d sync/blank=%b expected h=300 v=100 sync/blank=%b",
                         k, bus.hcount_out, bus.vcount_out,
                         {bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out}, {1'b1, 1'b0, (k == 0), (k == 1)});
            end
        end
    endtask

    task automatic test_blink();
        logic [4:0]  vis_tab;
        logic [11:0] want;
        vis_tab = 5'b11001;
        @(negedge pclk);
        #2 rst_n = 1'b0;
        repeat (2) drive_idle();
        rst_n       = 1'b1;
        bus.text_en = 1'b1;
        font_byte   = 8'hFF;
        for (int f = 0; f < 5; f++) begin
            frame_start(1'b1);
            drive_pixel(11'd300, 11'd100, 12'h0F0, 1'b0, 1'b0);
            drive_idle();
            drive_idle();
            @(negedge pclk);
            want = vis_tab[f] ? TC : 12'h0F0;
            checks++;
            if (bus.rgb_out !== want) begin
                errors++;
                $display("[TB] FAIL blink frame %0d: rgb_out=%h expected %h", f + 1, bus.rgb_out, want);
            end
        end
    endtask

    task automatic test_enable();
        logic [11:0] want;
        frame_start(1'b1);
        frame_start(1'b1);
        frame_start(1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) bus.text_en = 1'b0;
            if (k == 2) bus.text_en = 1'b1;
            if (k == 3) frame_start(1'b0);
            drive_pixel(11'd300, 11'd100, 12'h0C3, 1'b0, 1'b0);
            drive_idle();
            drive_idle();
            @(negedge pclk);
            want = (k == 3) ? 12'h0C3 : TC;
            checks++;
            if (bus.rgb_out !== want) begin
                errors++;
                $display("[TB] FAIL enable step %0d: rgb_out=%h expected %h", k, bus.rgb_out, want);
            end
        end
    endtask

    initial begin
        bus.text_en = 1'b0;
        set_inputs(11'd10, 11'd5, 12'h000, 1'b1, 1'b1);
        test_reset();
        test_glyph();
        test_box_edges();
        test_blanking();
        test_blink();
        test_enable();
        repeat (4) drive_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
